// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared encodings, FSM states and alignment check for the MSRV32 data-memory path
package msrv32_pkg;

   // load_size / store size encodings; 2'b11 is handled as a word
   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   // Halves need an even address, words (and the 2'b11 alias) a word-aligned one.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         LS_BYTE: mis = 1'b0;
         LS_HALF: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// rtl/msrv32_load_align.sv - lane extraction and sign/zero extension of a bus read word
// Ports:
//   rdata_in    : 32-bit word returned by the responder
//   off_in      : byte offset of the access within the word
//   size_in     : LS_BYTE / LS_HALF / LS_WORD (2'b11 treated as word)
//   unsigned_in : zero-extend instead of sign-extend
//   data_out    : extended 32-bit load result
module msrv32_load_align
   import msrv32_pkg::*;
(
   input  logic [31:0] rdata_in,
   input  logic [1:0]  off_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   output logic [31:0] data_out
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = rdata_in[7:0];
      case (off_in)
         2'd0: w_byte = rdata_in[7:0];
         2'd1: w_byte = rdata_in[15:8];
         2'd2: w_byte = rdata_in[23:16];
         2'd3: w_byte = rdata_in[31:24];
         default: w_byte = rdata_in[7:0];
      endcase
      w_half = off_in[1] ? rdata_in[31:16] : rdata_in[15:0];

      data_out = rdata_in;
      case (size_in)
         LS_BYTE: data_out = {{24{w_byte[7] & ~unsigned_in}}, w_byte};
         LS_HALF: data_out = {{16{w_half[15] & ~unsigned_in}}, w_half};
         default: data_out = rdata_in;
      endcase
   end

endmodule

// File: rtl/msrv32_dmem_bus_ctrl.sv
// rtl/msrv32_dmem_bus_ctrl.sv - req/ack data-memory bus initiator with stall, timeout and misalignment reporting
// Ports:
//   clk_in, reset_in        : clock, synchronous active-high reset
//   mem_req_in, mem_wr_in   : stage-3 load/store request and direction
//   iadder_in, rs2_in       : effective byte address, store data
//   load_size_in, load_unsigned_in : access size and zero-extend flag
//   dmem_ack_in, dmem_rdata_in     : responder completion and read word
//   dmem_req_out .. dmem_wr_mask_out : registered bus request fields
//   stall_out               : combinational pipeline hold
//   load_data_out, load_valid_out  : extended load result and its pulse
//   misaligned_out, bus_error_out  : rejection and timeout pulses
module msrv32_dmem_bus_ctrl
   import msrv32_pkg::*;
#(
   parameter int          ACK_TIMEOUT  = 16,
   parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        mem_req_in,
   input  logic        mem_wr_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   input  logic [1:0]  load_size_in,
   input  logic        load_unsigned_in,
   input  logic        dmem_ack_in,
   input  logic [31:0] dmem_rdata_in,
   output logic        dmem_req_out,
   output logic        dmem_wr_out,
   output logic [31:0] dmem_addr_out,
   output logic [31:0] dmem_wdata_out,
   output logic [3:0]  dmem_wr_mask_out,
   output logic        stall_out,
   output logic [31:0] load_data_out,
   output logic        load_valid_out,
   output logic        misaligned_out,
   output logic        bus_error_out
);

   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   state_t      r_state;
   state_t      w_next;
   logic [CW-1:0] r_cnt;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [31:0] w_align_data;
   logic [31:0] w_wdata;
   logic [3:0]  w_mask;
   logic        w_mis;
   logic        w_accept;
   logic        w_hit;

   msrv32_load_align u_align (
      .rdata_in    (dmem_rdata_in),
      .off_in      (r_off),
      .size_in     (r_size),
      .unsigned_in (r_unsigned),
      .data_out    (w_align_data)
   );

   always_comb begin
      w_mis    = is_misaligned(load_size_in, iadder_in[1:0]);
      w_accept = (r_state == IDLE) && mem_req_in && !w_mis;
      // Ack in the same cycle as the last counted cycle wins over the abort.
      w_hit    = (ACK_TIMEOUT != 0) && (r_state == REQ) && !dmem_ack_in
                 && (r_cnt == CW'(ACK_TIMEOUT - 1));

      w_next    = r_state;
      stall_out = 1'b0;
      case (r_state)
         IDLE: begin
            stall_out = w_accept;
            if (w_accept) w_next = REQ;
         end
         REQ: begin
            stall_out = !dmem_ack_in && !w_hit;
            if (dmem_ack_in || w_hit) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase

      // Lane replication lets the responder pick bytes by mask alone.
      case (load_size_in)
         LS_BYTE: begin
            w_wdata = {4{rs2_in[7:0]}};
            w_mask  = 4'b0001 << iadder_in[1:0];
         end
         LS_HALF: begin
            w_wdata = {2{rs2_in[15:0]}};
            w_mask  = 4'b0011 << iadder_in[1:0];
         end
         default: begin
            w_wdata = rs2_in;
            w_mask  = 4'b1111;
         end
      endcase
   end

   assign dmem_req_out = (r_state == REQ);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state          <= IDLE;
         r_cnt            <= '0;
         r_off            <= 2'b00;
         r_size           <= 2'b00;
         r_unsigned       <= 1'b0;
         dmem_wr_out      <= 1'b0;
         dmem_addr_out    <= BOOT_ADDRESS;
         dmem_wdata_out   <= 32'h0;
         dmem_wr_mask_out <= 4'b0000;
         load_data_out    <= 32'h0;
         load_valid_out   <= 1'b0;
         misaligned_out   <= 1'b0;
         bus_error_out    <= 1'b0;
      end else begin
         r_state        <= w_next;
         load_valid_out <= 1'b0;
         misaligned_out <= 1'b0;
         bus_error_out  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (mem_req_in && w_mis) misaligned_out <= 1'b1;
               if (w_accept) begin
                  r_cnt            <= '0;
                  r_off            <= iadder_in[1:0];
                  r_size           <= load_size_in;
                  r_unsigned       <= load_unsigned_in;
                  dmem_wr_out      <= mem_wr_in;
                  dmem_addr_out    <= {iadder_in[31:2], 2'b00};
                  dmem_wdata_out   <= w_wdata;
                  dmem_wr_mask_out <= mem_wr_in ? w_mask : 4'b0000;
               end
            end
            REQ: begin
               if (dmem_ack_in) begin
                  r_cnt <= '0;
                  if (!dmem_wr_out) begin
                     load_data_out  <= w_align_data;
                     load_valid_out <= 1'b1;
                  end
               end else if (w_hit) begin
                  r_cnt         <= '0;
                  bus_error_out <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_msrv32_dmem_bus_ctrl.sv
// tb/tb_msrv32_dmem_bus_ctrl.sv - scoreboard bench for msrv32_dmem_bus_ctrl
module tb_msrv32_dmem_bus_ctrl;

   localparam logic [31:0] BOOT = 32'h0000_0040;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        mem_req_in;
   logic        mem_wr_in;
   logic [31:0] iadder_in;
   logic [31:0] rs2_in;
   logic [1:0]  load_size_in;
   logic        load_unsigned_in;
   logic        dmem_ack_in;
   logic [31:0] dmem_rdata_in;
   logic        dmem_req_out;
   logic        dmem_wr_out;
   logic [31:0] dmem_addr_out;
   logic [31:0] dmem_wdata_out;
   logic [3:0]  dmem_wr_mask_out;
   logic        stall_out;
   logic [31:0] load_data_out;
   logic        load_valid_out;
   logic        misaligned_out;
   logic        bus_error_out;

   msrv32_dmem_bus_ctrl #(
      .ACK_TIMEOUT  (4),
      .BOOT_ADDRESS (BOOT)
   ) dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .mem_req_in       (mem_req_in),
      .mem_wr_in        (mem_wr_in),
      .iadder_in        (iadder_in),
      .rs2_in           (rs2_in),
      .load_size_in     (load_size_in),
      .load_unsigned_in (load_unsigned_in),
      .dmem_ack_in      (dmem_ack_in),
      .dmem_rdata_in    (dmem_rdata_in),
      .dmem_req_out     (dmem_req_out),
      .dmem_wr_out      (dmem_wr_out),
      .dmem_addr_out    (dmem_addr_out),
      .dmem_wdata_out   (dmem_wdata_out),
      .dmem_wr_mask_out (dmem_wr_mask_out),
      .stall_out        (stall_out),
      .load_data_out    (load_data_out),
      .load_valid_out   (load_valid_out),
      .misaligned_out   (misaligned_out),
      .bus_error_out    (bus_error_out)
   );

   always #5 clk_in = ~clk_in;

   // flags = {load_valid, misaligned, bus_error}
   typedef struct {
      logic [2:0]  flags;
      logic [31:0] data;
   } evt_t;

   evt_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every pulse on the result/event outputs must match the oldest expectation.
   always @(negedge clk_in) begin
      if (!reset_in && (load_valid_out || misaligned_out || bus_error_out)) begin
         if (q.size() == 0) begin
            check("unexpected_event", {29'd0, load_valid_out, misaligned_out, bus_error_out}, 32'd0);
         end else begin
            evt_t e;
            e = q.pop_front();
            check("event_kind", {29'd0, load_valid_out, misaligned_out, bus_error_out}, {29'd0, e.flags});
            if (e.flags[2]) check("load_data", load_data_out, e.data);
         end
      end
   end

   task automatic push(input logic [2:0] flags, input logic [31:0] data);
      evt_t e;
      e.flags = flags;
      e.data  = data;
      q.push_back(e);
   endtask

   // Starts at posedge+1 of the accept cycle; returns at posedge+1 of the cycle after completion.
   // ack_lat: REQ cycle index (0 = first REQ cycle) carrying the ack, -1 = never.
   task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input logic uns, input int ack_lat,
                         input logic [31:0] rd,
                         output int stalls, output int reqs, output logic [31:0] s_addr,
                         output logic s_wr, output logic [31:0] s_wdata, output logic [3:0] s_mask,
                         output logic stable);
      logic done;
      done    = 1'b0;
      stalls  = 0;
      reqs    = 0;
      stable  = 1'b1;
      s_addr  = 32'hx;
      s_wr    = 1'bx;
      s_wdata = 32'hx;
      s_mask  = 4'hx;
      mem_req_in       = 1'b1;
      mem_wr_in        = wr;
      iadder_in        = addr;
      rs2_in           = wd;
      load_size_in     = size;
      load_unsigned_in = uns;
      for (int c = 0; c < 40; c++) begin
         dmem_ack_in   = (c >= 1) && (c - 1 == ack_lat);
         dmem_rdata_in = dmem_ack_in ? rd : 32'h5555_5555;
         @(negedge clk_in);
         if (stall_out) stalls++;
         if (dmem_req_out) begin
            if (reqs == 0) begin
               s_addr  = dmem_addr_out;
               s_wr    = dmem_wr_out;
               s_wdata = dmem_wdata_out;
               s_mask  = dmem_wr_mask_out;
            end else if (s_addr !== dmem_addr_out || s_wr !== dmem_wr_out ||
                         s_wdata !== dmem_wdata_out || s_mask !== dmem_wr_mask_out) begin
               stable = 1'b0;
            end
            reqs++;
         end
         done = !stall_out;
         @(posedge clk_in);
         #1;
         if (done) break;
      end
      if (!done) check("access_bound", 32'd0, 32'd1);
      mem_req_in  = 1'b0;
      dmem_ack_in = 1'b0;
   endtask

   int          st, rq;
   logic [31:0] a, wd;
   logic        w, sb;
   logic [3:0]  m;

   initial begin
      reset_in = 1'b1; mem_req_in = 1'b0; mem_wr_in = 1'b0; iadder_in = 32'h0;
      rs2_in = 32'h0; load_size_in = 2'b00; load_unsigned_in = 1'b0;
      dmem_ack_in = 1'b0; dmem_rdata_in = 32'h0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_req", {31'd0, dmem_req_out}, 32'd0);
      check("rst_addr", dmem_addr_out, BOOT);
      check("rst_wdata", dmem_wdata_out, 32'd0);
      check("rst_misc", {26'd0, dmem_wr_out, dmem_wr_mask_out, stall_out},
            32'd0);
      check("rst_pulses", {29'd0, load_valid_out, misaligned_out, bus_error_out}, 32'd0);
      check("rst_ldata", load_data_out, 32'd0);
      @(posedge clk_in); #1;
      reset_in = 1'b0;
      @(posedge clk_in); #1;

      // word load, ack in the 4th REQ cycle
      push(3'b100, 32'hDEAD_BEEF);
      access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 3, 32'hDEAD_BEEF, st, rq, a, w, wd, m, sb);
      check("wl_addr", a, 32'h100);
      check("wl_mask", {28'd0, m}, 32'd0);
      check("wl_wr", {31'd0, w}, 32'd0);
      check("wl_stall", st, 4);
      check("wl_req", rq, 4);
      check("wl_stable", {31'd0, sb}, 32'd1);

      // signed and unsigned byte load at offset 3, back-to-back
      push(3'b100, 32'hFFFF_FF80);
      access(1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 1, 32'h80FF_0000, st, rq, a, w, wd, m, sb);
      check("bl_addr", a, 32'h200);
      check("bl_stall", st, 2);
      push(3'b100, 32'h0000_0080);
      access(1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 0, 32'h80FF_0000, st, rq, a, w, wd, m, sb);
      check("blu_stall", st, 1);

      // half store, same-cycle ack
      access(1'b1, 32'h302, 32'h1234_ABCD, 2'b01, 1'b0, 0, 32'h0, st, rq, a, w, wd, m, sb);
      check("hs_addr", a, 32'h300);
      check("hs_wdata", wd, 32'hABCD_ABCD);
      check("hs_mask", {28'd0, m}, 32'hC);
      check("hs_wr", {31'd0, w}, 32'd1);
      check("hs_req", rq, 1);

      // byte store lane 1
      access(1'b1, 32'h001, 32'h0000_005A, 2'b00, 1'b0, 2, 32'h0, st, rq, a, w, wd, m, sb);
      check("bs_wdata", wd, 32'h5A5A_5A5A);
      check("bs_mask", {28'd0, m}, 32'h2);
      check("bs_stable", {31'd0, sb}, 32'd1);

      // half loads: upper lane signed, lower lane unsigned; size 11 as word
      push(3'b100, 32'hFFFF_8001);
      access(1'b0, 32'h002, 32'h0, 2'b01, 1'b0, 0, 32'h8001_7FFF, st, rq, a, w, wd, m, sb);
      push(3'b100, 32'h0000_F00F);
      access(1'b0, 32'h000, 32'h0, 2'b01, 1'b1, 0, 32'h1234_F00F, st, rq, a, w, wd, m, sb);
      push(3'b100, 32'h8765_4321);
      access(1'b0, 32'h010, 32'h0, 2'b11, 1'b0, 0, 32'h8765_4321, st, rq, a, w, wd, m, sb);

      // misaligned word and half
      push(3'b010, 32'h0);
      access(1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 0, 32'h0, st, rq, a, w, wd, m, sb);
      check("mis_stall", st, 0);
      check("mis_req", rq, 0);
      push(3'b010, 32'h0);
      access(1'b1, 32'h003, 32'h0, 2'b01, 1'b0, 0, 32'h0, st, rq, a, w, wd, m, sb);
      check("mish_req", rq, 0);
      @(negedge clk_in);
      check("mis_req_after", {31'd0, dmem_req_out}, 32'd0);
      @(posedge clk_in); #1;

      // timeout, then a late ack in IDLE
      push(3'b001, 32'h0);
      access(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, -1, 32'h0, st, rq, a, w, wd, m, sb);
      check("to_req", rq, 4);
      check("to_stall", st, 4);
      dmem_ack_in = 1'b1;
      dmem_rdata_in = 32'h1111_1111;
      @(negedge clk_in);
      check("to_idle_req", {31'd0, dmem_req_out}, 32'd0);
      check("to_idle_stall", {31'd0, stall_out}, 32'd0);
      @(posedge clk_in); #1;
      dmem_ack_in = 1'b0;
      @(negedge clk_in);
      check("late_ack_ign", {31'd0, load_valid_out}, 32'd0);
      @(posedge clk_in); #1;

      // reset in the second REQ cycle
      mem_req_in = 1'b1; mem_wr_in = 1'b1; iadder_in = 32'h500; rs2_in = 32'hCAFE_F00D;
      load_size_in = 2'b10;
      @(posedge clk_in); #1;
      mem_req_in = 1'b0;
      @(posedge clk_in); #1;
      reset_in = 1'b1;
      @(posedge clk_in); #1;
      reset_in = 1'b0;
      check("mr_req", {31'd0, dmem_req_out}, 32'd0);
      check("mr_addr", dmem_addr_out, BOOT);
      check("mr_bus", {dmem_wdata_out[27:0], dmem_wr_out, dmem_wr_mask_out[2:0]}, 32'd0);
      check("mr_stall", {31'd0, stall_out}, 32'd0);
      push(3'b100, 32'h0000_00A5);
      access(1'b0, 32'h601, 32'h0, 2'b00, 1'b1, 1, 32'h0000_A500, st, rq, a, w, wd, m, sb);
      check("mr_next_addr", a, 32'h600);
      check("mr_next_req", rq, 2);

      repeat (3) @(posedge clk_in);
      check("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/msrv32_dmem_bus_ctrl.md
Name: msrv32_dmem_bus_ctrl

Overview:
Data-memory bus initiator for the MSRV32 core. It consumes the stage-3 registered load/store fields (effective address from iadder, store data from rs2, load_size, load_unsigned) and runs a req/ack transaction on the data bus. It stalls the pipeline until the responder acknowledges or a timeout fires. It returns aligned, sign/zero-extended load data to writeback and flags misaligned accesses instead of issuing them.

Parameters:
ACK_TIMEOUT, 16, cycles in REQ without ack before abort; 0 disables the timeout.
BOOT_ADDRESS, 32'h00000000, reset value of dmem_addr_out.

Ports:
clk_in  input  1  core clock
reset_in  input  1  synchronous reset, active-high
mem_req_in  input  1  stage-3 instruction is a load or store
mem_wr_in  input  1  1 = store, 0 = load
iadder_in  input  32  effective byte address
rs2_in  input  32  store data
load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
load_unsigned_in  input  1  zero-extend loads
dmem_ack_in  input  1  responder completes the access
dmem_rdata_in  input  32  read word, valid with ack
dmem_req_out  output  1  bus request
dmem_wr_out  output  1  request is a write
dmem_addr_out  output  32  word-aligned address, bits [1:0] = 00
dmem_wdata_out  output  32  lane-replicated store data
dmem_wr_mask_out  output  4  byte enables; 0000 on loads
stall_out  output  1  hold the pipeline (combinational)
load_data_out  output  32  extended load result
load_valid_out  output  1  one-cycle pulse with load_data_out
misaligned_out  output  1  one-cycle pulse, access rejected
bus_error_out  output  1  one-cycle pulse, timeout abort

Behaviour:
- Reset values: state IDLE; all outputs 0; dmem_addr_out = BOOT_ADDRESS; timeout counter 0. A reset mid-transaction drops the request at once. There is no bus handshake on reset.
- Misaligned access: a half with addr[0]=1, or a word with addr[1:0]!=0.
  - No bus request is made and there is no stall.
  - misaligned_out is registered high for exactly one cycle (cycle T+1).
- IDLE, with an aligned mem_req_in at cycle T:
  - stall_out = 1 in cycle T.
  - Latch the word address, byte offset, size, unsigned flag, write flag, wdata and mask.
  - Move to REQ. dmem_req_out = 1 from T+1.
- Store lanes:
  - byte: wdata = {4{rs2[7:0]}}, mask = 0001 << off.
  - half: wdata = {2{rs2[15:0]}}, mask = 0011 << off.
  - word: wdata = rs2, mask = 1111.
- REQ:
  - All dmem_* outputs are held stable until ack.
  - stall_out = ~dmem_ack_in & ~timeout_hit.
  - The timeout counter increments each cycle without ack. timeout_hit is asserted when count == ACK_TIMEOUT-1 and ACK_TIMEOUT != 0.
- Ack at cycle T+k:
  - stall_out goes low in that same cycle, so the pipeline advances at that edge.
  - Next cycle: state IDLE, dmem_req_out = 0, counter cleared.
  - For a load, load_data_out is registered and load_valid_out pulses at T+k+1.
  - For a store, no load_valid_out pulse.
- Timeout: in the timeout_hit cycle, stall_out = 0. Next cycle: req dropped, bus_error_out pulses once, state IDLE, and load_valid_out does not assert.
- Load extraction, with off = latched byte offset:
  - byte: rdata[8*off +: 8].
  - half: rdata[16*off[1] +: 16].
  - word: full 32 bits.
  - Sign-extend unless load_unsigned is set.
- load_data_out holds its value until the next load completes.
- dmem_ack_in while in IDLE is ignored.
- Minimum access: 2 cycles (accept, then REQ with same-cycle ack). Back-to-back accesses are accepted in the IDLE cycle right after completion.
- A late ack after a timeout, arriving while in IDLE, is ignored.

Decomposition:
- Package msrv32_pkg holds:
  - LS_BYTE/LS_HALF/LS_WORD encodings.
  - The FSM state enum {IDLE, REQ}.
  - The misalignment check function.
- Sub-module msrv32_load_align: combinational extraction and extension from (rdata, off, size, unsigned) to 32-bit data.

Test Plan:
- Word load at 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> addr 0x100, mask 0000, stall for 4 cycles, load_data 0xDEADBEEF with a single valid pulse.
- Signed byte load at 0x203, rdata 0x80FF_0000 -> load_data 0xFFFFFF80. Same access with unsigned -> 0x00000080.
- Half store of rs2 0x1234ABCD at 0x302, same-cycle ack -> addr 0x300, wdata 0xABCDABCD, mask 1100, wr=1, no load_valid.
- Word load at 0x101 -> no dmem_req, no stall, misaligned_out pulses once.
- No ack with ACK_TIMEOUT=4 -> req high 4 cycles, then dropped, bus_error_out single pulse, IDLE. A later ack is ignored.
- reset_in asserted in the second REQ cycle -> next cycle all outputs 0 and IDLE. A subsequent access runs normally.
